// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op/state encodings for the HI/LO multiply-divide unit.
// Default operand width lives here so the sequencer and step agree.
package muldiv_pkg;

  localparam int MULDIV_DATA_W = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration on {acc,q}.
// Multiply: conditional add then shift right. Divide: shift left, restoring subtract.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int DATA_W = MULDIV_DATA_W
) (
  input  logic              is_div,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] m,
  output logic [DATA_W-1:0] acc_n,
  output logic [DATA_W-1:0] q_n
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] shl;
  logic [DATA_W:0] diff;
  logic [DATA_W:0] part;

  // single add-shift or subtract-restore step
  always_comb begin
    sum   = {1'b0, acc} + {1'b0, m};
    shl   = {acc, q[DATA_W-1]};
    diff  = shl - {1'b0, m};
    part  = q[0] ? sum : {1'b0, acc};
    acc_n = acc;
    q_n   = q;
    if (is_div) begin
      if (shl >= {1'b0, m}) begin
        acc_n = diff[DATA_W-1:0];
        q_n   = {q[DATA_W-2:0], 1'b1};
      end else begin
        acc_n = shl[DATA_W-1:0];
        q_n   = {q[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_n = part[DATA_W:1];
      q_n   = {part[0], q[DATA_W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Build option MULDIV_DIVZERO_FAST_EN: divide by zero skips the iteration phase.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int                 DATA_W   = MULDIV_DATA_W,
  parameter logic [DATA_W-1:0]  HILO_RST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int COUNT_W = $clog2(DATA_W) + 1;

  state_e              state;
  state_e              next_state;
  logic [COUNT_W-1:0]  counter;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   q;
  logic [DATA_W-1:0]   m;
  logic [DATA_W-1:0]   acc_n;
  logic [DATA_W-1:0]   q_n;
  logic                is_div;
  logic                neg_q;
  logic                neg_r;
  logic                done_q;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;

  logic                is_signed;
  logic                a_neg;
  logic                b_neg;
  logic [DATA_W-1:0]   a_mag;
  logic [DATA_W-1:0]   b_mag;
  logic                fast;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   quo;
  logic [DATA_W-1:0]   rem;

  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed & a[DATA_W-1];
  assign b_neg     = is_signed & b[DATA_W-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

`ifdef MULDIV_DIVZERO_FAST_EN
  assign fast = op[1] && (b == '0);
`else
  assign fast = 1'b0;
`endif

  assign prod = neg_q ? -{acc, q} : {acc, q};
  assign quo  = neg_q ? -q : q;
  assign rem  = neg_r ? -acc : acc;

  muldiv_step #(
    .DATA_W(DATA_W)
  ) u_step (
    .is_div(is_div),
    .acc   (acc),
    .q     (q),
    .m     (m),
    .acc_n (acc_n),
    .q_n   (q_n)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      S_IDLE: if (start) next_state = fast ? S_FIX : S_CALC;
      S_CALC: if (counter == COUNT_W'(1)) next_state = S_FIX;
      S_FIX:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      acc     <= '0;
      q       <= '0;
      m       <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            is_div  <= op[1];
            neg_q   <= a_neg ^ b_neg;
            neg_r   <= a_neg;
            counter <= COUNT_W'(DATA_W);
            acc     <= '0;
            if (op[1]) begin
              m <= b_mag;
              q <= a_mag;
              if (fast) begin
                acc <= a_mag;
                q   <= '1;
              end
            end else begin
              m <= a_mag;
              q <= b_mag;
            end
          end
        end
        S_CALC: begin
          acc     <= acc_n;
          q       <= q_n;
          counter <= counter - COUNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: result write in S_FIX, MTHI/MTLO only when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= HILO_RST;
      lo_q <= HILO_RST;
    end else if (state == S_FIX) begin
      if (is_div) begin
        hi_q <= rem;
        lo_q <= quo;
      end else begin
        hi_q <= prod[2*DATA_W-1:DATA_W];
        lo_q <= prod[DATA_W-1:0];
      end
    end else if (state == S_IDLE) begin
      if (mthi) hi_q <= wdata;
      if (mtlo) lo_q <= wdata;
    end
  end

  // done pulse follows the result write
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == S_FIX);
  end

  assign busy = (state != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with a result scoreboard.
// Latency expectations follow MULDIV_DIVZERO_FAST_EN when defined.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;
  logic [63:0] expq[$];
  logic prev_done = 1'b0;

`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int DZ_LAT = 2;
`else
  localparam int DZ_LAT = 34;
`endif

  muldiv_sequencer dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .mthi (mthi),
    .mtlo (mtlo),
    .wdata(wdata),
    .busy (busy),
    .done (done),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: compare every done pulse against the scoreboard
  always @(negedge clk) begin
    if (done === 1'b1) begin
      chk("done_single", {63'd0, prev_done}, 64'd0);
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done", hi, lo);
      end else begin
        chk("result", {hi, lo}, expq.pop_front());
      end
    end
    prev_done = (done === 1'b1);
  end

  task automatic wait_done(output int n, output int nb);
    bit got;
    got = 0;
    n = 0;
    nb = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (done) got = 1;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [63:0] exp,
                        input int lat);
    int n;
    int nb;
    expq.push_back(exp);
    @(negedge clk);
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom);
    a = $urandom;
    b = $urandom;
    wait_done(n, nb);
    chk("latency", 64'(n), 64'(lat));
    chk("busy_cycles", 64'(nb), 64'(lat - 1));
  endtask

  initial begin
    int n;
    int nb;
    logic [31:0] lo_prev;
    reset = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, 34);
    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 64'hFFFFFFFF_FFFFFFF1, 34);
    run_op(2'b10, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 34);
    run_op(2'b11, 32'd7, 32'd0, 64'h00000007_FFFFFFFF, DZ_LAT);
    run_op(2'b10, 32'hFFFFFFF9, 32'd0, 64'hFFFFFFF9_00000001, DZ_LAT);
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34);
    run_op(2'b01, 32'h12345678, 32'h10, 64'h00000001_23456780, 34);
    run_op(2'b00, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000, 34);
    run_op(2'b11, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

    @(negedge clk);
    mthi = 1'b1;
    wdata = 32'h1234;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    @(negedge clk);
    chk("mthi", {hi, lo}, 64'h00001234_0000000E);

    mtlo = 1'b1;
    wdata = 32'h0000BEEF;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    @(negedge clk);
    chk("mtlo", {hi, lo}, 64'h00001234_0000BEEF);

    mthi = 1'b1;
    mtlo = 1'b1;
    wdata = 32'h5A5A5A5A;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    @(negedge clk);
    chk("mthi_mtlo", {hi, lo}, 64'h5A5A5A5A_5A5A5A5A);

    expq.push_back(64'h00000000_00000014);
    op = 2'b01;
    a = 32'd4;
    b = 32'd5;
    start = 1'b1;
    mthi = 1'b1;
    wdata = 32'h0000AAAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi = 1'b0;
    @(negedge clk);
    chk("mthi_with_start", {32'd0, hi}, 64'h0000AAAA);
    wait_done(n, nb);
    chk("latency_mthi_start", 64'(n), 64'd33);

    expq.push_back(64'h00000000_00000006);
    @(negedge clk);
    op = 2'b01;
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    lo_prev = lo;
    op = 2'b11;
    a = 32'd9;
    b = 32'd1;
    start = 1'b1;
    mtlo = 1'b1;
    wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("mtlo_busy", {32'd0, lo}, {32'd0, lo_prev});
    start = 1'b0;
    mtlo = 1'b0;
    wait_done(n, nb);
    chk("busy_ignore_lat", 64'(n), 64'd28);
    repeat (40) @(negedge clk);
    chk("no_restart", {63'd0, busy}, 64'd0);

    op = 2'b11;
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_idle", {hi, lo}, 64'd0);

    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
